// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: decoupled fetch front end. It issues in-order word
// fetches to a pipelined memory under a credit limit of DEPTH, buffers the
// returned {word, pc} pairs in a DEPTH-entry FIFO, and hands them to decode
// over a valid/ready handshake. A redirect flushes the FIFO and discards the
// responses still in flight.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// the outputs when the FIFO is empty, giving zero-cycle response latency.
module instruction_fetch_queue #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  output logic        o_MemRequest,
  output logic [31:0] o_MemAddress,
  input  logic        i_MemGrant,
  input  logic        i_MemValid,
  input  logic [31:0] i_MemData,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectAddress,
  output logic        o_InstructionValid,
  output logic [31:0] o_InstructionWord,
  output logic [31:0] o_InstructionPointer,
  input  logic        i_InstructionReady
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

  logic [31:0]   fetchPc;
  logic [31:0]   wordMem  [DEPTH];
  logic [31:0]   pcMem    [DEPTH];
  logic [31:0]   reqPcMem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr, reqRdPtr, reqWrPtr;
  logic [CW-1:0] count, outstanding, drop, outstandingNext;

  logic grant, respAccept, fifoValid, bypassHit, enq, pop;
  logic [31:0] respPc;
  logic [1:0]  unusedRedirLsbs;

  assign unusedRedirLsbs = i_RedirectAddress[1:0];

  assign grant      = o_MemRequest && i_MemGrant;
  // A response with nothing in flight is a protocol violation and is ignored.
  assign respAccept = i_MemValid && (outstanding != '0);
  assign respPc     = reqPcMem[reqRdPtr];
  assign fifoValid  = (count != '0);

`ifdef FETCH_BYPASS_EN
  assign bypassHit = !fifoValid && (drop == '0) && respAccept && !i_Redirect;
`else
  assign bypassHit = 1'b0;
`endif

  // A bypassed response consumed in the same cycle never touches the FIFO.
  assign enq = respAccept && (drop == '0) && !i_Redirect && !(bypassHit && i_InstructionReady);
  assign pop = fifoValid && i_InstructionReady && !i_Redirect;

  assign o_MemRequest = !i_Reset && !i_Redirect &&
                        (({1'b0, count} + {1'b0, outstanding}) < CREDIT_LIMIT);
  assign o_MemAddress = fetchPc;

  assign o_InstructionValid   = fifoValid || bypassHit;
  assign o_InstructionWord    = fifoValid ? wordMem[rdPtr] : (bypassHit ? i_MemData : '0);
  assign o_InstructionPointer = fifoValid ? pcMem[rdPtr]   : (bypassHit ? respPc    : '0);

  assign outstandingNext = outstanding + CW'(grant) - CW'(respAccept);

  // Storage arrays: data FIFO and the in-flight request PC FIFO (never flushed,
  // so stale responses still pop their own PC and stay paired).
  always_ff @(posedge i_Clock) begin
    if (enq) begin
      wordMem[wrPtr] <= i_MemData;
      pcMem[wrPtr]   <= respPc;
    end
    if (grant) reqPcMem[reqWrPtr] <= fetchPc;
  end

  // Control state: fetch PC, pointers, occupancy, in-flight and drop counters.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      fetchPc     <= RESET_VECTOR;
      rdPtr       <= '0;
      wrPtr       <= '0;
      reqRdPtr    <= '0;
      reqWrPtr    <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (grant)      reqWrPtr <= reqWrPtr + AW'(1);
      if (respAccept) reqRdPtr <= reqRdPtr + AW'(1);
      if (i_Redirect) begin
        fetchPc <= {i_RedirectAddress[31:2], 2'b00};
        rdPtr   <= wrPtr;
        count   <= '0;
        // Everything still in flight after this cycle belongs to the old path.
        drop    <= outstandingNext;
      end else begin
        if (grant) fetchPc <= fetchPc + 32'd4;
        if (enq)   wrPtr   <= wrPtr + AW'(1);
        if (pop)   rdPtr   <= rdPtr + AW'(1);
        count <= count + CW'(enq) - CW'(pop);
        if (respAccept && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end
endmodule
